out_port: RTL and testbench
===========================

// Module: out_port
// PURPOSE
//  Output port: the transmit-side counterpart of the interconnect input port.
//  - Core writes 32-bit words into one of three logical ports; each port is a DEPTH-entry FIFO.
//  - The CCM selects a port per cycle via i_addr. The block drives {valid,data} on data_out
//    and retires a word only when downstream valid_back (block) is low one cycle later.
//  - Sits between the core write interface and the interconnect data bus.
// PARAMETERS
//  DATA_W   32  payload width; data_out is DATA_W+1 bits with valid at the MSB
//  DEPTH    2   entries per port, power of two, >=2
// PORTS
//  gclock      in   1         system clock, all logic on rising edge
//  reset       in   1         asynchronous, active-high reset
//  c_addr      in   2         core port select; 0..2 valid, 3 = no-op
//  c_write     in   1         core write strobe, one word per gclock when high
//  c_data      in   DATA_W    core write data
//  ready       out  3         per-port "has free slot" flag to core
//  i_addr      in   2         CCM port select for this cycle; 3 = idle
//  data_out    out  DATA_W+1  {valid, payload} to interconnect, registered
//  valid_back  in   1         downstream block: 1 = last offered word NOT accepted
// BEHAVIOUR
//  Reset (async, active-high):
//  - all FIFO counts and pointers = 0; data_out = 0; pend_vld = 0.
//  - ready = 3'b000 while reset is high, and reflects state from the first edge after release.
//  Core write, sampled at posedge gclock:
//  - c_write && c_addr!=3 && count[c_addr]<DEPTH: store c_data at wr_ptr, then wr_ptr++ and count++.
//  - Write to a full port: the word is dropped and FIFO state is unchanged.
//  - c_addr==3: ignored.
//  - ready[p] = (count[p] < DEPTH), combinational from registered count.
//  Offer (cycle N), at posedge:
//  - If i_addr!=3 && count[i_addr]>0 && !(pend_vld && pend_port==i_addr):
//    data_out <= {1'b1, head[i_addr]}, pend_port <= i_addr, pend_vld <= 1.
//  - Otherwise data_out <= {1'b0, DATA_W'b0} and pend_vld <= 0.
//  - A port with an outstanding offer is never re-offered in the next cycle, so no duplicates.
//  Resolve (posedge ending cycle N+1):
//  - If pend_vld was 1 and valid_back==0: pop pend_port (rd_ptr++, count--).
//  - If valid_back==1: the word stays at head and is re-offered on a later selection.
//  - valid_back is ignored when pend_vld==0.
//  Simultaneous write and pop on the same port in one edge: both occur and count is unchanged.
//  - A pop frees a slot visible on ready one cycle later; a write on that same edge to a port that
//    was full is still rejected.
//  Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits and never exceeds DEPTH or drops below 0.
//  Reset mid-transfer:
//  - pending offer discarded, buffered words lost, data_out valid drops immediately.
//  - No pop is performed on the first edge after reset release.
//  Latency: core write to first possible offer = 1 cycle; offer to retire = 1 cycle.
// CONFIGURATION
//  OUT_PORT_ERR_EN defined:
//  - Adds output err [2:0]. err[p] is set sticky when a core write targets full port p.
//  - err is cleared only by reset; reset value 0.
//  OUT_PORT_ERR_EN undefined:
//  - No err port; overflow writes are silently dropped. All other behaviour is identical.
// TESTING
//  1 Reset, write 0xA5A5_0001 to port 1, i_addr=1, valid_back=0
//    -> data_out=33'h1_A5A5_0001 one cycle later; count[1]=0 and ready[1]=1 after resolve.
//  2 Fill port 0 with 0x11, 0x22, then write 0x33
//    -> ready[0]=0; 0x33 dropped (err[0]=1 with OUT_PORT_ERR_EN); port 0 drains 0x11 then 0x22 only.
//  3 Offer port 2 word 0xBEEF with valid_back=1, then re-select port 2 two cycles later with valid_back=0
//    -> 0xBEEF offered twice and popped once; next offer is the following word.
//  4 Hold i_addr=0 every cycle with 2 words queued and valid_back=0
//    -> offers alternate valid/idle (no re-offer while pending); both words delivered in order, no duplicate.
//  5 Port 1 full; same edge: c_write to port 1 and resolve pop of port 1
//    -> write rejected, count[1]=DEPTH-1, ready[1]=1 next cycle.
//  6 Assert reset while an offer is pending with 1 word queued
//    -> data_out=0 immediately, ready=000, after release all counts 0 and no spurious pop.

Source files
------------

// File: rtl/out_port.sv
// Transmit-side output port: three DEPTH-entry FIFOs written by the core, offered to the
// interconnect under CCM selection, retired when valid_back is low. OUT_PORT_ERR_EN adds err.
module out_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              gclock,
  input  logic              reset,
  input  logic [1:0]        c_addr,
  input  logic              c_write,
  input  logic [DATA_W-1:0] c_data,
  output logic [2:0]        ready,
  input  logic [1:0]        i_addr,
  output logic [DATA_W:0]   data_out,
  input  logic              valid_back
`ifdef OUT_PORT_ERR_EN
  ,
  output logic [2:0]        err
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [DATA_W-1:0] mem_q     [3][DEPTH];
  logic [PtrW-1:0]   wr_ptr_q  [3];
  logic [PtrW-1:0]   rd_ptr_q  [3];
  logic [CntW-1:0]   count_q   [3];
  logic              pend_vld_q;
  logic [1:0]        pend_port_q;

  logic [2:0]        wr_en;
  logic [2:0]        pop;
  logic              sel_nonempty;
  logic [DATA_W-1:0] sel_head;
  logic              offer;

  // Write acceptance uses the pre-pop count, so a same-edge pop never admits a write to a full port.
  always_comb begin
    wr_en        = '0;
    pop          = '0;
    ready        = '0;
    sel_nonempty = 1'b0;
    sel_head     = '0;
    for (int p = 0; p < 3; p++) begin
      wr_en[p] = c_write && (c_addr == 2'(p)) && (count_q[p] != Full);
      pop[p]   = pend_vld_q && !valid_back && (pend_port_q == 2'(p));
      ready[p] = !reset && (count_q[p] != Full);
      if (i_addr == 2'(p)) begin
        sel_nonempty = (count_q[p] != '0);
        sel_head     = mem_q[p][rd_ptr_q[p]];
      end
    end
  end

  // A port with an outstanding offer is skipped so the same word is never offered twice.
  assign offer = (i_addr != 2'd3) && sel_nonempty && !(pend_vld_q && (pend_port_q == i_addr));

  always_ff @(posedge gclock) begin
    for (int p = 0; p < 3; p++) begin
      if (wr_en[p]) begin
        mem_q[p][wr_ptr_q[p]] <= c_data;
      end
    end
  end

  always_ff @(posedge gclock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 3; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
      pend_vld_q  <= 1'b0;
      pend_port_q <= 2'd0;
      data_out    <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (wr_en[p]) begin
          wr_ptr_q[p] <= wr_ptr_q[p] + PtrW'(1);
        end
        if (pop[p]) begin
          rd_ptr_q[p] <= rd_ptr_q[p] + PtrW'(1);
        end
        if (wr_en[p] && !pop[p]) begin
          count_q[p] <= count_q[p] + CntW'(1);
        end else if (pop[p] && !wr_en[p]) begin
          count_q[p] <= count_q[p] - CntW'(1);
        end
      end
      pend_vld_q <= offer;
      if (offer) begin
        pend_port_q <= i_addr;
        data_out    <= {1'b1, sel_head};
      end else begin
        data_out    <= '0;
      end
    end
  end

`ifdef OUT_PORT_ERR_EN
  always_ff @(posedge gclock or posedge reset) begin
    if (reset) begin
      err <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (c_write && (c_addr == 2'(p)) && (count_q[p] == Full)) begin
          err[p] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_out_port.sv
// Directed self-checking bench for out_port (DATA_W=32, DEPTH=2).
module tb_out_port;

  logic        gclock = 1'b0;
  logic        reset;
  logic [1:0]  c_addr;
  logic        c_write;
  logic [31:0] c_data;
  logic [2:0]  ready;
  logic [1:0]  i_addr;
  logic [32:0] data_out;
  logic        valid_back;
`ifdef OUT_PORT_ERR_EN
  logic [2:0]  err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  out_port #(.DATA_W(32), .DEPTH(2)) dut (
    .gclock     (gclock),
    .reset      (reset),
    .c_addr     (c_addr),
    .c_write    (c_write),
    .c_data     (c_data),
    .ready      (ready),
    .i_addr     (i_addr),
    .data_out   (data_out),
    .valid_back (valid_back)
`ifdef OUT_PORT_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 gclock = ~gclock;

  task automatic tick();
    @(posedge gclock);
    #1;
  endtask

  task automatic wr(input logic [1:0] port, input logic [31:0] d);
    c_write = 1'b1; c_addr = port; c_data = d;
    tick();
    c_write = 1'b0; c_addr = 2'd3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (data_out !== 33'h0) begin n_bad++; $display("FAIL reset_data: got %h want %h", data_out, 33'h0); end
    n_cmp++;
    if (ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want %b", ready, 3'b000); end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 3'b111) begin n_bad++; $display("FAIL post_reset_ready: got %b want %b", ready, 3'b111); end
`ifdef OUT_PORT_ERR_EN
    n_cmp++;
    if (err !== 3'b000) begin n_bad++; $display("FAIL reset_err: got %b want %b", err, 3'b000); end
`endif
  endtask

  task automatic test_single();
    wr(2'd1, 32'hA5A5_0001);
    i_addr = 2'd1; valid_back = 1'b0;
    tick();
    n_cmp++;
    if (data_out !== 33'h1_A5A5_0001) begin n_bad++; $display("FAIL single_offer: got %h want %h", data_out, 33'h1_A5A5_0001); end
    i_addr = 2'd3;
    tick();
    n_cmp++;
    if (data_out !== 33'h0) begin n_bad++; $display("FAIL single_idle: got %h want %h", data_out, 33'h0); end
    n_cmp++;
    if (ready !== 3'b111) begin n_bad++; $display("FAIL single_ready: got %b want %b", ready, 3'b111); end
    i_addr = 2'd1;
    tick();
    n_cmp++;
    if (data_out !== 33'h0) begin n_bad++; $display("FAIL single_empty: got %h want %h", data_out, 33'h0); end
    i_addr = 2'd3;
  endtask

  task automatic test_overflow();
    wr(2'd0, 32'h11);
    n_cmp++;
    if (ready !== 3'b111) begin n_bad++; $display("FAIL ovf_ready1: got %b want %b", ready, 3'b111); end
    wr(2'd0, 32'h22);
    n_cmp++;
    if (ready !== 3'b110) begin n_bad++; $display("FAIL ovf_ready2: got %b want %b", ready, 3'b110); end
    wr(2'd0, 32'h33);
    n_cmp++;
    if (ready !== 3'b110) begin n_bad++; $display("FAIL ovf_ready3: got %b want %b", ready, 3'b110); end
`ifdef OUT_PORT_ERR_EN
    n_cmp++;
    if (err !== 3'b001) begin n_bad++; $display("FAIL ovf_err: got %b want %b", err, 3'b001); end
`endif
    valid_back = 1'b0;
    i_addr = 2'd0; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_0011) begin n_bad++; $display("FAIL ovf_first: got %h want %h", data_out, 33'h1_0000_0011); end
    i_addr = 2'd3; tick();
    i_addr = 2'd0; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_0022) begin n_bad++; $display("FAIL ovf_second: got %h want %h", data_out, 33'h1_0000_0022); end
    i_addr = 2'd3; tick();
    i_addr = 2'd0; tick();
    n_cmp++;
    if (data_out !== 33'h0) begin n_bad++; $display("FAIL ovf_dropped: got %h want %h", data_out, 33'h0); end
    i_addr = 2'd3; tick();
    n_cmp++;
    if (ready !== 3'b111) begin n_bad++; $display("FAIL ovf_drained: got %b want %b", ready, 3'b111); end
  endtask

  task automatic test_retry();
    wr(2'd2, 32'hBEEF);
    wr(2'd2, 32'hCAFE);
    i_addr = 2'd2; valid_back = 1'b0; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_BEEF) begin n_bad++; $display("FAIL retry_first: got %h want %h", data_out, 33'h1_0000_BEEF); end
    i_addr = 2'd3; valid_back = 1'b1; tick();
    n_cmp++;
    if (ready !== 3'b011) begin n_bad++; $display("FAIL retry_kept: got %b want %b", ready, 3'b011); end
    i_addr = 2'd2; valid_back = 1'b0; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_BEEF) begin n_bad++; $display("FAIL retry_again: got %h want %h", data_out, 33'h1_0000_BEEF); end
    i_addr = 2'd3; tick();
    i_addr = 2'd2; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_CAFE) begin n_bad++; $display("FAIL retry_next: got %h want %h", data_out, 33'h1_0000_CAFE); end
    i_addr = 2'd3; tick();
    n_cmp++;
    if (ready !== 3'b111) begin n_bad++; $display("FAIL retry_drained: got %b want %b", ready, 3'b111); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_seq [5];
    exp_seq[0] = 33'h1_0000_0044;
    exp_seq[1] = 33'h0;
    exp_seq[2] = 33'h1_0000_0055;
    exp_seq[3] = 33'h0;
    exp_seq[4] = 33'h0;
    wr(2'd0, 32'h44);
    wr(2'd0, 32'h55);
    i_addr = 2'd0; valid_back = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (data_out !== exp_seq[k]) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: got %h want %h", k, data_out, exp_seq[k]);
      end
    end
    i_addr = 2'd3;
  endtask

  task automatic test_full_pop();
    wr(2'd1, 32'h66);
    wr(2'd1, 32'h77);
    n_cmp++;
    if (ready !== 3'b101) begin n_bad++; $display("FAIL fp_full: got %b want %b", ready, 3'b101); end
    i_addr = 2'd1; valid_back = 1'b0; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_0066) begin n_bad++; $display("FAIL fp_offer: got %h want %h", data_out, 33'h1_0000_0066); end
    // Pop and rejected write on the same edge.
    i_addr = 2'd3;
    wr(2'd1, 32'h88);
    n_cmp++;
    if (ready !== 3'b111) begin n_bad++; $display("FAIL fp_ready: got %b want %b", ready, 3'b111); end
`ifdef OUT_PORT_ERR_EN
    n_cmp++;
    if (err !== 3'b011) begin n_bad++; $display("FAIL fp_err: got %b want %b", err, 3'b011); end
`endif
    i_addr = 2'd1; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_0077) begin n_bad++; $display("FAIL fp_head: got %h want %h", data_out, 33'h1_0000_0077); end
    i_addr = 2'd3; tick();
    i_addr = 2'd1; tick();
    n_cmp++;
    if (data_out !== 33'h0) begin n_bad++; $display("FAIL fp_empty: got %h want %h", data_out, 33'h0); end
    i_addr = 2'd3; tick();
  endtask

  task automatic test_reset_mid();
    wr(2'd2, 32'h99);
    i_addr = 2'd2; valid_back = 1'b0; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_0099) begin n_bad++; $display("FAIL rm_offer: got %h want %h", data_out, 33'h1_0000_0099); end
    i_addr = 2'd3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (data_out !== 33'h0) begin n_bad++; $display("FAIL rm_data: got %h want %h", data_out, 33'h0); end
    n_cmp++;
    if (ready !== 3'b000) begin n_bad++; $display("FAIL rm_ready: got %b want %b", ready, 3'b000); end
    tick();
    reset = 1'b0;
    // A stale pending offer must not pop the word written on the first edge after release.
    wr(2'd2, 32'hAA);
    n_cmp++;
    if (ready !== 3'b111) begin n_bad++; $display("FAIL rm_ready_after: got %b want %b", ready, 3'b111); end
`ifdef OUT_PORT_ERR_EN
    n_cmp++;
    if (err !== 3'b000) begin n_bad++; $display("FAIL rm_err: got %b want %b", err, 3'b000); end
`endif
    i_addr = 2'd2; tick();
    n_cmp++;
    if (data_out !== 33'h1_0000_00AA) begin n_bad++; $display("FAIL rm_new_word: got %h want %h", data_out, 33'h1_0000_00AA); end
    i_addr = 2'd3; tick();
  endtask

  initial begin
    reset = 1'b1; c_addr = 2'd3; c_write = 1'b0; c_data = '0;
    i_addr = 2'd3; valid_back = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_retry();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
